// File: rtl/sr_cond_pkg.sv
// Shared types and constants for the set/clear input conditioner.
package sr_cond_pkg;

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_HIGH     = 2'd1,
        ST_CONFLICT = 2'd2
    } sr_state_t;

    localparam int SYNC_STAGES    = 2;
    localparam int CONFLICT_CNT_W = 8;

endpackage

// File: rtl/sr_input_conditioner_debounce.sv
// Two-flop synchronizer plus stability counter for one raw request line.
module sr_debounce
    import sr_cond_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int              CNT_W  = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // raw goes straight into the first flop; nothing combinational in front of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            level <= 1'b0;
        end else if (sync_lvl == level) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_TC) begin
            cnt_q <= '0;
            level <= sync_lvl;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sr_input_conditioner.sv
// Set/clear request conditioner: debounced inputs resolved into one registered level.
// Optional saturating conflict-entry counter enabled by SR_CONFLICT_CNT_EN.
//
// state       | meaning
// ST_LOW      | d_out = 0, clear request last won
// ST_HIGH     | d_out = 1, set request last won
// ST_CONFLICT | both requests active, d_out = SET_PRIORITY
module sr_input_conditioner
    import sr_cond_pkg::*;
#(
    parameter int DEB_CYCLES   = 16,
    parameter int SET_PRIORITY = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_raw,
    input  logic clr_raw,
    output logic d_out,
    output logic set_pulse,
    output logic clr_pulse,
    output logic conflict
`ifdef SR_CONFLICT_CNT_EN
    ,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);

    localparam logic      PRIO_LVL = (SET_PRIORITY != 0);
    localparam sr_state_t ST_EXIT  = PRIO_LVL ? ST_HIGH : ST_LOW;

    logic      s_db;
    logic      c_db;
    sr_state_t state_q;
    sr_state_t state_d;
    logic      d_nxt;
    logic      set_nxt;
    logic      clr_nxt;
    logic      conflict_nxt;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (set_raw),
        .level (s_db)
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (clr_raw),
        .level (c_db)
    );

    // Outputs are registered alongside the state so d_out never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOW;
            d_out     <= 1'b0;
            set_pulse <= 1'b0;
            clr_pulse <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_out     <= d_nxt;
            set_pulse <= set_nxt;
            clr_pulse <= clr_nxt;
            conflict  <= conflict_nxt;
        end
    end

    always_comb begin
        state_d = state_q;
        case ({s_db, c_db})
            2'b10:   state_d = ST_HIGH;
            2'b01:   state_d = ST_LOW;
            2'b11:   state_d = ST_CONFLICT;
            default: if (state_q == ST_CONFLICT) state_d = ST_EXIT;
        endcase
    end

    always_comb begin
        d_nxt        = (state_d == ST_HIGH) || ((state_d == ST_CONFLICT) && PRIO_LVL);
        set_nxt      = d_nxt & ~d_out;
        clr_nxt      = ~d_nxt & d_out;
        conflict_nxt = (state_d == ST_CONFLICT);
    end

`ifdef SR_CONFLICT_CNT_EN
    // Counts entries only; staying in conflict does not advance the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if ((state_d == ST_CONFLICT) && (state_q != ST_CONFLICT)
                     && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Bench for sr_input_conditioner: clear- and set-priority instances, table vectors,
// corner sequences and random stimulus against a behavioural model.
module tb_sr_input_conditioner;
    import sr_cond_pkg::*;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_raw = 1'b0;
    logic clr_raw = 1'b0;

    logic d0, sp0, cp0, cf0;
    logic d1, sp1, cp1, cf1;
`ifdef SR_CONFLICT_CNT_EN
    logic [CONFLICT_CNT_W-1:0] cnt0, cnt1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sr_input_conditioner #(.DEB_CYCLES(DEB), .SET_PRIORITY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .set_raw(set_raw), .clr_raw(clr_raw),
        .d_out(d0), .set_pulse(sp0), .clr_pulse(cp0), .conflict(cf0)
`ifdef SR_CONFLICT_CNT_EN
        , .conflict_cnt(cnt0)
`endif
    );

    sr_input_conditioner #(.DEB_CYCLES(DEB), .SET_PRIORITY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .set_raw(set_raw), .clr_raw(clr_raw),
        .d_out(d1), .set_pulse(sp1), .clr_pulse(cp1), .conflict(cf1)
`ifdef SR_CONFLICT_CNT_EN
        , .conflict_cnt(cnt1)
`endif
    );

    // Output vectors are {d_out, set_pulse, clr_pulse, conflict} in the low nibble.
    logic [7:0] o0, o1;
    assign o0 = {4'b0, d0, sp0, cp0, cf0};
    assign o1 = {4'b0, d1, sp1, cp1, cf1};

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a level changes once the last DEB synchronized samples all
    // disagree with it; the resolved output follows the plain set/clear rules.
    logic [1:0]     m_ssync, m_csync;
    logic [DEB-1:0] m_shist, m_chist, sw, cw;
    logic           m_sdb, m_cdb, m_conf;
    logic [1:0]     m_d, m_sp, m_cp;
    logic [7:0]     m_cnt;
    logic [7:0]     m0, m1;
    assign m0 = {4'b0, m_d[0], m_sp[0], m_cp[0], m_conf};
    assign m1 = {4'b0, m_d[1], m_sp[1], m_cp[1], m_conf};

    function automatic logic resolve(logic s, logic c, logic prev, logic prio);
        if (s && !c) return 1'b1;
        if (!s && c) return 1'b0;
        if (s && c)  return prio;
        return prev;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ssync <= '0; m_csync <= '0;
            m_shist <= '0; m_chist <= '0;
            m_sdb <= 1'b0; m_cdb <= 1'b0; m_conf <= 1'b0;
            m_d <= '0; m_sp <= '0; m_cp <= '0;
            m_cnt <= '0;
        end else begin
            sw = {m_shist[DEB-2:0], m_ssync[1]};
            cw = {m_chist[DEB-2:0], m_csync[1]};
            m_shist <= sw;
            m_chist <= cw;
            m_ssync <= {m_ssync[0], set_raw};
            m_csync <= {m_csync[0], clr_raw};
            if (sw == {DEB{~m_sdb}}) m_sdb <= ~m_sdb;
            if (cw == {DEB{~m_cdb}}) m_cdb <= ~m_cdb;
            for (int p = 0; p < 2; p++) begin
                logic nd;
                nd = resolve(m_sdb, m_cdb, m_d[p], p[0]);
                m_sp[p] <= nd & ~m_d[p];
                m_cp[p] <= ~nd & m_d[p];
                m_d[p]  <= nd;
            end
            m_conf <= m_sdb & m_cdb;
            if (m_sdb && m_cdb && !m_conf && m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
        end
    end

    always @(negedge clk) begin
        chk("model0", o0, m0);
        chk("model1", o1, m1);
`ifdef SR_CONFLICT_CNT_EN
        chk("model_cnt0", cnt0, m_cnt);
        chk("model_cnt1", cnt1, m_cnt);
`endif
    end

    typedef struct {
        logic       s;
        logic       c;
        int         hold;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8, 8'h08, 8'h08};
        tbl[1] = '{1'b1, 1'b1, 8, 8'h01, 8'h09};
        tbl[2] = '{1'b0, 1'b1, 8, 8'h00, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 8, 8'h01, 8'h09};
        tbl[4] = '{1'b0, 1'b0, 8, 8'h00, 8'h08};
        tbl[5] = '{1'b1, 1'b0, 8, 8'h08, 8'h08};
        tbl[6] = '{1'b0, 1'b0, 8, 8'h08, 8'h08};
        tbl[7] = '{1'b0, 1'b1, 8, 8'h00, 8'h00};
        tbl[8] = '{1'b0, 1'b0, 8, 8'h00, 8'h00};

        // Reset with set held, then full latency after release
        rst_n = 1'b0; set_raw = 1'b1; clr_raw = 1'b0;
        nclk(3);
        chk("rst_out0", o0, 8'h00);
        chk("rst_out1", o1, 8'h00);
        rst_n = 1'b1;
        nclk(6);
        chk("rst_lat_early", o0, 8'h00);
        nclk(1);
        chk("rst_lat_rise0", o0, 8'h0C);
        chk("rst_lat_rise1", o1, 8'h0C);
        nclk(1);
        chk("rst_pulse_end", o0, 8'h08);

        // Return to low, then a 3-cycle glitch must be rejected
        set_raw = 1'b0; clr_raw = 1'b1; nclk(10);
        clr_raw = 1'b0; nclk(10);
        chk("low_again", o0, 8'h00);
        set_raw = 1'b1; nclk(3); set_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            nclk(1);
            chk("glitch", o0 & 8'h0E, 8'h00);
        end
        set_raw = 1'b1;
        nclk(6);
        chk("stable_early", o0, 8'h00);
        nclk(1);
        chk("stable_rise", o0, 8'h0C);

        // Conflict with clear priority, then clear released while set remains
        clr_raw = 1'b1;
        nclk(6);
        chk("cf_pre", o0, 8'h08);
        nclk(1);
        chk("cf_enter0", o0, 8'h03);
        chk("cf_enter1", o1, 8'h09);
        nclk(1);
        chk("cf_hold0", o0, 8'h01);
        clr_raw = 1'b0;
        nclk(6);
        chk("cf_exit_pre", o0, 8'h01);
        nclk(1);
        chk("cf_exit0", o0, 8'h0C);
        chk("cf_exit1", o1, 8'h08);

        // Both raised together from low: set-priority instance goes high
        set_raw = 1'b0; clr_raw = 1'b1; nclk(10);
        clr_raw = 1'b0; nclk(10);
        set_raw = 1'b1; clr_raw = 1'b1;
        nclk(6);
        chk("sp_pre1", o1, 8'h00);
        nclk(1);
        chk("sp_enter1", o1, 8'h0D);
        chk("sp_enter0", o0, 8'h01);
        set_raw = 1'b0; clr_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            nclk(1);
            chk("sp_drop1", o1 & 8'h0E, 8'h08);
            chk("sp_drop0", o0 & 8'h0E, 8'h00);
        end
        chk("sp_final1", o1, 8'h08);

        // Async reset two edges into a debounce
        set_raw = 1'b1; clr_raw = 1'b1; nclk(10);
        clr_raw = 1'b0;
        nclk(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_now0", o0, 8'h00);
        chk("arst_now1", o1, 8'h00);
        nclk(1);
        rst_n = 1'b1;
        nclk(6);
        chk("arst_early", o1, 8'h00);
        nclk(1);
        chk("arst_rise0", o0, 8'h0C);
        chk("arst_rise1", o1, 8'h0C);

        // Table-driven settled behaviour
        rst_n = 1'b0; set_raw = 1'b0; clr_raw = 1'b0;
        nclk(2);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_raw = tbl[i].s;
            clr_raw = tbl[i].c;
            nclk(tbl[i].hold);
            chk("tbl0", o0, tbl[i].exp0);
            chk("tbl1", o1, tbl[i].exp1);
        end

        // Random levels with occasional resets, checked every cycle by the model
        for (int i = 0; i < 300; i++) begin
            set_raw = 1'($urandom_range(0, 1));
            clr_raw = 1'($urandom_range(0, 1));
            nclk($urandom_range(1, 9));
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                nclk(1);
                rst_n = 1'b1;
            end
        end

`ifdef SR_CONFLICT_CNT_EN
        rst_n = 1'b0; set_raw = 1'b0; clr_raw = 1'b0;
        nclk(2);
        rst_n = 1'b1;
        set_raw = 1'b1; nclk(8);
        clr_raw = 1'b1; nclk(27);
        chk("cnt_stay", cnt0, 8'd1);
        clr_raw = 1'b0; nclk(8);
        for (int i = 1; i < 300; i++) begin
            clr_raw = 1'b1; nclk(17);
            clr_raw = 1'b0; nclk(8);
        end
        chk("cnt_sat0", cnt0, 8'd255);
        chk("cnt_sat1", cnt1, 8'd255);
`endif

        nclk(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
